// File: rtl/iob_fifo_reader_pkg.sv
// Package for iob_fifo_reader: buffer depth, counter width and derived widths.
`include "iob_fifo_reader.vh"

package iob_fifo_reader_pkg;

   localparam int unsigned BUF_DEPTH = `IOB_FIFO_READER_BUF_DEPTH;
   localparam int unsigned CNT_W     = `IOB_FIFO_READER_CNT_W;
   localparam int unsigned LEVEL_W   = $clog2(BUF_DEPTH + 1);
   localparam int unsigned OCC_W     = LEVEL_W + 1;

endpackage

// File: rtl/iob_fifo_reader.vh
// Shared sizing constants for the iob_fifo_reader block.
`ifndef IOB_FIFO_READER_VH
`define IOB_FIFO_READER_VH

`define IOB_FIFO_READER_BUF_DEPTH 2
`define IOB_FIFO_READER_CNT_W     32

`endif

// File: rtl/iob_fifo_reader_buf.sv
// Two-entry output skid buffer: head entry drives the stream, tail absorbs one extra word.
module iob_fifo_reader_buf
   import iob_fifo_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [LEVEL_W-1:0]    level
);

   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] tail_q;
   logic [LEVEL_W-1:0]    level_q;

   // Head only changes on pop or when the buffer is empty, so it is stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (level_q == '0) begin
                  head_q <= din;
               end else begin
                  tail_q <= din;
               end
               level_q <= level_q + LEVEL_W'(1);
            end
            2'b01: begin
               head_q  <= tail_q;
               level_q <= level_q - LEVEL_W'(1);
            end
            2'b11: begin
               if (level_q == LEVEL_W'(1)) begin
                  head_q <= din;
               end else begin
                  head_q <= tail_q;
                  tail_q <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign dout  = head_q;
   assign level = level_q;

endmodule

// File: rtl/iob_fifo_reader.sv
// Streams words out of a sync FIFO (1-cycle read latency) onto a valid/ready port.
// Define IOB_FIFO_READER_CNT_EN to enable the accepted-word counter on word_count.
module iob_fifo_reader
   import iob_fifo_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_read_en,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_W-1:0]      word_count
);

   logic               inflight_q;
   logic               pop;
   logic               rd_en;
   logic [LEVEL_W-1:0] level;
   logic [OCC_W-1:0]   occupancy;

   // Buffered plus in-flight words must never exceed the buffer depth; a pop frees a slot this cycle.
   assign occupancy = OCC_W'(level) + OCC_W'(inflight_q);
   assign m_valid   = (level != '0);
   assign pop       = m_valid & m_ready;
   assign rd_en     = ~rst & en & ~fifo_empty & ((occupancy < OCC_W'(BUF_DEPTH)) | pop);

   assign fifo_read_en = rd_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_en;
      end
   end

   iob_fifo_reader_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_buf (
      .clk  (clk),
      .rst  (rst),
      .push (inflight_q),
      .pop  (pop),
      .din  (fifo_data_out),
      .dout (m_data),
      .level(level)
   );

`ifdef IOB_FIFO_READER_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (pop) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign word_count = cnt_q;
`else
   assign word_count = '0;
`endif

endmodule

// File: tb/tb_iob_fifo_reader.sv
// Bench for iob_fifo_reader: queue-based FIFO and stream model, directed scenarios plus random traffic.
module tb_iob_fifo_reader;

   localparam int unsigned DW = 8;
`ifdef IOB_FIFO_READER_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data_out;
   logic          fifo_read_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [31:0]   word_count;

   iob_fifo_reader #(.DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .fifo_empty   (fifo_empty),
      .fifo_data_out(fifo_data_out),
      .fifo_read_en (fifo_read_en),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .word_count   (word_count)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fifo_q[$];
   exp_t          exp_q[$];
   logic [DW-1:0] got_q[$];
   logic          rst_nxt, en_nxt, rdy_nxt;
   logic          pend_v;
   logic [DW-1:0] pend_d;
   logic          prev_stall;
   logic [DW-1:0] prev_data;
   logic [31:0]   model_cnt;
   logic          last_rd, last_mv;
   int            cyc, reads, n_tests, n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs at negedge, check against the model, then advance the model.
   task automatic step();
      logic mv_exp, pop_exp, rd_exp;
      @(negedge clk);
      rst           = rst_nxt;
      en            = en_nxt;
      m_ready       = rdy_nxt;
      fifo_data_out = pend_v ? pend_d : DW'($urandom);
      pend_v        = 1'b0;
      fifo_empty    = (fifo_q.size() == 0);
      #1;
      cyc++;
      last_rd = fifo_read_en;
      last_mv = m_valid;
      if (rst) begin
         chk("rst_m_valid", 64'(m_valid), 64'(0));
         chk("rst_read_en", 64'(fifo_read_en), 64'(0));
         chk("rst_word_count", 64'(word_count), 64'(0));
         exp_q.delete();
         model_cnt  = '0;
         prev_stall = 1'b0;
      end else begin
         mv_exp  = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc - 2);
         pop_exp = mv_exp & m_ready;
         rd_exp  = en & ~fifo_empty & ((exp_q.size() - int'(pop_exp)) < 2);
         chk("m_valid", 64'(m_valid), 64'(mv_exp));
         if (mv_exp) chk("m_data", 64'(m_data), 64'(exp_q[0].data));
         chk("fifo_read_en", 64'(fifo_read_en), 64'(rd_exp));
         chk("word_count", 64'(word_count), CNT_ON ? 64'(model_cnt) : 64'(0));
         if (prev_stall) chk("stall_hold", 64'(m_data), 64'(prev_data));
         prev_stall = m_valid & ~m_ready;
         prev_data  = m_data;
         if (pop_exp) begin
            void'(exp_q.pop_front());
            got_q.push_back(m_data);
            model_cnt++;
         end
         if (fifo_read_en && fifo_q.size() > 0) begin
            pend_d = fifo_q.pop_front();
            pend_v = 1'b1;
            exp_q.push_back('{pend_d, cyc});
            reads++;
            chk("no_overflow", 64'(exp_q.size() <= 2), 64'(1));
         end
      end
   endtask

   task automatic drain();
      int guard;
      guard   = 0;
      en_nxt  = 1'b1;
      rdy_nxt = 1'b1;
      while ((fifo_q.size() > 0 || exp_q.size() > 0 || pend_v) && guard < 60) begin
         step();
         guard++;
      end
      chk("drain_timeout", 64'(guard < 60), 64'(1));
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; reads = 0;
      pend_v = 1'b0; pend_d = '0; prev_stall = 1'b0; prev_data = '0; model_cnt = '0;
      rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data_out = '0;
      rst_nxt = 1'b1; en_nxt = 1'b1; rdy_nxt = 1'b1;
      fifo_q.push_back(8'h77);
      repeat (3) step();
      fifo_q.delete();
      rst_nxt = 1'b0;
      step();

      // Streaming 0x01..0x05 at full rate
      for (int i = 1; i <= 5; i++) fifo_q.push_back(DW'(i));
      got_q.delete();
      for (int i = 0; i < 8; i++) begin
         step();
         chk("stream_rd", 64'(last_rd), 64'(i < 5));
         chk("stream_valid", 64'(last_mv), 64'(i >= 2 && i < 7));
      end
      chk("stream_count", 64'(got_q.size()), 64'(5));

      // Backpressure: only two reads while stalled, head held at 0x01
      for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
      rdy_nxt = 1'b0;
      reads   = 0;
      got_q.delete();
      repeat (10) step();
      chk("bp_reads", 64'(reads), 64'(2));
      chk("bp_head", 64'(m_data), 64'(8'h01));
      drain();
      chk("bp_delivered", 64'(got_q.size()), 64'(4));
      chk("bp_last", 64'(got_q[3]), 64'(8'h04));

      // Single word into empty FIFO
      repeat (3) step();
      reads = 0;
      got_q.delete();
      fifo_q.push_back(8'hA5);
      repeat (6) step();
      chk("empty_reads", 64'(reads), 64'(1));
      chk("empty_words", 64'(got_q.size()), 64'(1));
      chk("empty_data", 64'(got_q[0]), 64'(8'hA5));
      chk("empty_idle_valid", 64'(last_mv), 64'(0));

      // en drops right after a read is issued
      for (int i = 0; i < 3; i++) fifo_q.push_back(DW'(8'h10 + i));
      reads = 0;
      got_q.delete();
      step();
      en_nxt = 1'b0;
      repeat (5) step();
      chk("endrop_reads", 64'(reads), 64'(1));
      chk("endrop_words", 64'(got_q.size()), 64'(1));
      chk("endrop_data", 64'(got_q[0]), 64'(8'h10));
      drain();

      // Reset with the buffer full
      for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(8'h20 + i));
      rdy_nxt = 1'b0;
      repeat (4) step();
      chk("pre_rst_valid", 64'(last_mv), 64'(1));
      rst_nxt = 1'b1;
      step();
      rst_nxt = 1'b0;
      got_q.delete();
      drain();
      chk("post_rst_first", 64'(got_q[0]), 64'(8'h22));
      chk("post_rst_words", 64'(got_q.size()), 64'(4));

      // Random traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) < 45) fifo_q.push_back(DW'($urandom));
         en_nxt  = ($urandom_range(0, 3) != 0);
         rdy_nxt = ($urandom_range(0, 9) < 6);
         rst_nxt = ($urandom_range(0, 249) == 0);
         step();
      end
      rst_nxt = 1'b0;
      drain();
      chk("final_idle_valid", 64'(last_mv), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
